// File: rtl/fb_scanout_pkg.sv
// Shared sizing helpers and swap FSM state for the framebuffer scanout.
// Optional macro: FB_SCANOUT_MARGIN_EN (black margin lines above/below).
package fb_scanout_pkg;

  localparam int DEF_BUF = 320 * 240;

  typedef enum logic {
    SW_WAIT,
    SW_DONE
  } swap_st_t;

  function automatic int total(
    input int act,
    input int fp,
    input int sw,
    input int bp,
    input int mg
  );
    return act + fp + sw + bp + 2 * mg;
  endfunction

  function automatic int buf_words(
    input int w,
    input int h
  );
    return w * h;
  endfunction

  function automatic int addr_w(
    input int w,
    input int h
  );
    return $clog2(2 * buf_words(w, h));
  endfunction

endpackage

// File: rtl/fb_timing_gen.sv
// Raster counters with active/sync/blank flags of the current state.
// VOFF shifts the active window down (margin build, FB_SCANOUT_MARGIN_EN).
module fb_timing_gen
  import fb_scanout_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int HFP    = 8,
  parameter int HSW    = 32,
  parameter int HBP    = 40,
  parameter int VFP    = 3,
  parameter int VSW    = 4,
  parameter int VBP    = 15,
  parameter int VOFF   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic ce_pix,
  output logic act,
  output logic hsync,
  output logic vsync,
  output logic hblank,
  output logic vblank,
  output logic act_next,
  output logic first_next,
  output logic swap_next,
  output logic wrap,
  output logic frame_start
);

  localparam int HT  = total(WIDTH, HFP, HSW, HBP, 0);
  localparam int VT  = total(HEIGHT, VFP, VSW, VBP, VOFF);
  localparam int HW  = $clog2(HT);
  localparam int VW  = $clog2(VT);
  localparam int VA1 = VOFF + HEIGHT;
  localparam int VBL = HEIGHT + 2 * VOFF;
  localparam int VS0 = VBL + VFP;
  localparam int HS0 = WIDTH + HFP;

  logic [HW-1:0] hcnt;
  logic [HW-1:0] hnx;
  logic [VW-1:0] vcnt;
  logic [VW-1:0] vnx;
  logic          eol;

  function automatic logic in_act(
    input logic [HW-1:0] h,
    input logic [VW-1:0] v
  );
    return (int'(h) < WIDTH) &&
           (int'(v) >= VOFF) &&
           (int'(v) < VA1);
  endfunction

  assign eol  = int'(hcnt) == HT - 1;
  assign wrap = eol && (int'(vcnt) == VT - 1);

  always_comb begin
    hnx = eol ? '0 : hcnt + HW'(1);
    vnx = vcnt;
    if (wrap)
      vnx = '0;
    else if (eol)
      vnx = vcnt + VW'(1);
  end

  assign act        = in_act(hcnt, vcnt);
  assign act_next   = in_act(hnx, vnx);
  assign first_next = act_next && (hnx == '0) &&
                      (int'(vnx) == VOFF);
  assign swap_next  = eol && (int'(vnx) == VA1);

  assign hblank = !(int'(hcnt) < WIDTH);
  assign vblank = !(int'(vcnt) < VBL);
  assign hsync  = (int'(hcnt) >= HS0) &&
                  (int'(hcnt) < HS0 + HSW);
  assign vsync  = (int'(vcnt) >= VS0) &&
                  (int'(vcnt) < VS0 + VSW);

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= ce_pix && wrap;
      if (ce_pix) begin
        hcnt <= hnx;
        vcnt <= vnx;
      end
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// Double-buffered framebuffer reader: address gen, vblank swap, output regs.
// Define FB_SCANOUT_MARGIN_EN to add MARGIN black lines above and below.
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter  int WIDTH  = 320,
  parameter  int HEIGHT = 240,
  parameter  int DEPTH  = 8,
  parameter  int HFP    = 8,
  parameter  int HSW    = 32,
  parameter  int HBP    = 40,
  parameter  int VFP    = 3,
  parameter  int VSW    = 4,
  parameter  int VBP    = 15,
  parameter  int MARGIN = 4,
  localparam int AW     = addr_w(WIDTH, HEIGHT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             front,
  output logic [AW-1:0]    rd_addr,
  input  logic [DEPTH-1:0] rd_data,
  output logic [DEPTH-1:0] video_out,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank,
  output logic             vblank,
  output logic             frame_start
);

`ifdef FB_SCANOUT_MARGIN_EN
  localparam int VOFF = MARGIN;
`else
  localparam int VOFF = 0 * MARGIN;
`endif

  localparam logic [AW-1:0] BASE1 =
    AW'(buf_words(WIDTH, HEIGHT));

  logic     act_d;
  logic     hs;
  logic     vs;
  logic     hb;
  logic     vb;
  logic     act_next;
  logic     first_next;
  logic     swap_next;
  logic     wrap;
  swap_st_t st;

  fb_timing_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .HFP   (HFP),
    .HSW   (HSW),
    .HBP   (HBP),
    .VFP   (VFP),
    .VSW   (VSW),
    .VBP   (VBP),
    .VOFF  (VOFF)
  ) u_tg (
    .clk        (clk),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .act        (act_d),
    .hsync      (hs),
    .vsync      (vs),
    .hblank     (hb),
    .vblank     (vb),
    .act_next   (act_next),
    .first_next (first_next),
    .swap_next  (swap_next),
    .wrap       (wrap),
    .frame_start(frame_start)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= SW_WAIT;
      front     <= 1'b0;
      swap_ack  <= 1'b0;
      rd_addr   <= '0;
      video_out <= '0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      hblank    <= 1'b1;
      vblank    <= 1'b1;
    end else begin
      swap_ack <= 1'b0;
      if (ce_pix) begin
        video_out <= act_d ? rd_data : '0;
        hsync     <= hs;
        vsync     <= vs;
        hblank    <= hb;
        vblank    <= vb;
        // frame origin and first visible pixel both reload the base
        if (wrap || first_next)
          rd_addr <= front ? BASE1 : '0;
        else if (act_next)
          rd_addr <= rd_addr + AW'(1);
        unique case (st)
          SW_WAIT:
            if (swap_next && swap_req) begin
              front    <= !front;
              swap_ack <= 1'b1;
              st       <= SW_DONE;
            end
          SW_DONE:
            if (wrap)
              st <= SW_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: 4x3 raster, unit porches, RAM[i] = i.
// Works with or without FB_SCANOUT_MARGIN_EN (MARGIN = 1).
module tb_fb_scanout;

`ifdef FB_SCANOUT_MARGIN_EN
  localparam int VOFF = 1;
`else
  localparam int VOFF = 0;
`endif
  localparam int HT = 7;
  localparam int VT = 6 + 2 * VOFF;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_pix = 1'b0;
  logic       swap_req = 1'b0;
  logic       swap_ack;
  logic       front;
  logic [4:0] rd_addr;
  logic [7:0] rd_data = 8'd0;
  logic [7:0] video_out;
  logic       hsync;
  logic       vsync;
  logic       hblank;
  logic       vblank;
  logic       frame_start;
  logic [7:0] mem [0:23];

  int vecs = 0;
  int errs = 0;
  int n = 0;
  int efront = 0;
  int bbase = 0;
  int acks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  fb_scanout #(
    .WIDTH (4),
    .HEIGHT(3),
    .DEPTH (8),
    .HFP   (1),
    .HSW   (1),
    .HBP   (1),
    .VFP   (1),
    .VSW   (1),
    .VBP   (1),
    .MARGIN(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .front      (front),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .video_out  (video_out),
    .hsync      (hsync),
    .vsync      (vsync),
    .hblank     (hblank),
    .vblank     (vblank),
    .frame_start(frame_start)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s n=%0d got %0d exp %0d",
               tag, n, got, exp);
    end
  endtask

  function automatic bit act_at(input int p);
    int h = p % HT;
    int v = p / HT;
    return h < 4 && v >= VOFF && v < VOFF + 3;
  endfunction

  function automatic int addr_at(input int p, input int b);
    int h = p % HT;
    int v = p / HT;
    if (v < VOFF) return b;
    if (v < VOFF + 3) return b + (v - VOFF) * 4 + (h < 3 ? h : 3);
    return b + 11;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    ce_pix = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
    check("rst_video", video_out, 0);
    check("rst_hsync", hsync, 0);
    check("rst_vsync", vsync, 0);
    check("rst_hblank", hblank, 1);
    check("rst_vblank", vblank, 1);
    check("rst_ack", swap_ack, 0);
    check("rst_fstart", frame_start, 0);
    check("rst_front", front, 0);
    check("rst_addr", rd_addr, 0);
    reset  = 1'b0;
    n      = 0;
    efront = 0;
    bbase  = 0;
  endtask

  task automatic tick();
    int p;
    int q;
    int h;
    int v;
    int obase;
    int eack;
    p = (n + 1) % FT;
    q = n % FT;
    eack = 0;
    if (p == HT * (3 + VOFF) && swap_req) begin
      efront ^= 1;
      eack = 1;
    end
    obase = bbase;
    if (p == 0) bbase = efront ? 12 : 0;
    @(negedge clk);
    ce_pix = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
    n++;
    h = q % HT;
    v = q / HT;
    if (swap_ack === 1'b1) acks++;
    check("video", video_out, act_at(q) ? addr_at(q, obase) : 0);
    check("hblank", hblank, h >= 4);
    check("vblank", vblank, v >= 3 + 2 * VOFF);
    check("hsync", hsync, h == 5);
    check("vsync", vsync, v == 4 + 2 * VOFF);
    check("rd_addr", rd_addr, addr_at(p, bbase));
    check("fstart", frame_start, p == 0);
    check("front", front, efront);
    check("ack", swap_ack, eack);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog n=%0d", n);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 24; i++) mem[i] = 8'(i);
    do_reset();
    repeat (10) tick();
    swap_req = 1'b1;
    repeat (FT - 10) tick();
    check("ack_first", acks, 1);
    swap_req = 1'b0;
    repeat (FT) tick();
    acks = 0;
    swap_req = 1'b1;
    repeat (3 * FT) tick();
    check("ack_3frames", acks, 3);
    repeat (HT * (3 + VOFF)) tick();
    check("front_pre_rst", front, 1);
    swap_req = 1'b0;
    while ((n % FT) != 2 * HT + 1) tick();
    do_reset();
    repeat (FT + 5) tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
